// File: rtl/prm_edge_scan_ctrl_pkg.sv
// Shared FSM state type and default widths for the PRM edge-query scan sequencer.
package prm_scan_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_FLUSH,
        SCAN_DONE
    } scan_state_e;

    localparam int unsigned SCAN_QW = 15;
    localparam int unsigned SCAN_WW = 32;
    localparam int unsigned SCAN_CW = 16;

endpackage

// File: rtl/prm_edge_scan_ctrl_packer.sv
// Bit accumulator, bit-position counter and single-entry word holding register with
// valid/ready; reports a stall when a word must move out but the holding slot is busy.
module prm_scan_packer
    import prm_scan_pkg::*;
#(
    parameter int unsigned WW = SCAN_WW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          sample_en_i,
    input  logic          sample_i,
    input  logic          last_i,
    output logic          stall_o,
    output logic [WW-1:0] word_o,
    output logic          word_vld_o,
    input  logic          word_rdy_i,
    output logic          word_last_o
);

    localparam int unsigned   BW      = $clog2(WW);
    localparam logic [BW-1:0] TOP_POS = BW'(WW - 1);

    logic [WW-1:0] acc_q, acc_d;
    logic [WW-1:0] word_q, word_d;
    logic [BW-1:0] pos_q, pos_d;
    logic          vld_q, vld_d;
    logic          last_q, last_d;
    logic [WW-1:0] merged;
    logic          xfer;
    logic          take;

    always_comb begin
        merged          = acc_q;
        merged[pos_q]   = sample_i;
        xfer            = (pos_q == TOP_POS) || last_i;
        stall_o         = xfer && vld_q && !word_rdy_i;
        take            = sample_en_i && !stall_o;

        acc_d  = acc_q;
        pos_d  = pos_q;
        word_d = word_q;
        vld_d  = vld_q;
        last_d = last_q;

        if (vld_q && word_rdy_i) begin
            vld_d = 1'b0;
        end

        if (clear_i) begin
            acc_d = '0;
            pos_d = '0;
        end else if (take) begin
            // A load here may coincide with acceptance of the previous word.
            if (xfer) begin
                acc_d  = '0;
                pos_d  = '0;
                word_d = merged;
                vld_d  = 1'b1;
                last_d = last_i;
            end else begin
                acc_d = merged;
                pos_d = pos_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            pos_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            pos_q  <= pos_d;
            word_q <= word_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign word_o      = word_q;
    assign word_vld_o  = vld_q;
    assign word_last_o = last_q;

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Walks a contiguous range of edge-query codes, samples the checker result and packs
// it into bitmap words. Optional blocked-edge popcount behind `PRM_SCAN_POPCNT_EN`.
module prm_edge_scan_ctrl
    import prm_scan_pkg::*;
#(
    parameter int unsigned QW = SCAN_QW,
    parameter int unsigned WW = SCAN_WW,
    parameter int unsigned CW = SCAN_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [QW-1:0] base_i,
    input  logic [CW-1:0] count_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [QW-1:0] query_o,
    output logic          query_vld_o,
    input  logic          edge_mask_i,
    output logic [WW-1:0] word_o,
    output logic          word_vld_o,
    input  logic          word_rdy_i,
    output logic          word_last_o
`ifdef PRM_SCAN_POPCNT_EN
    ,
    output logic [CW-1:0] blocked_cnt_o
`endif
);

    scan_state_e   state_q, state_d;
    logic [QW-1:0] query_q, query_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          accept;
    logic          last_sample;
    logic          stall;
    logic          take;

    always_comb begin
        state_d     = state_q;
        query_d     = query_q;
        rem_d       = rem_q;
        accept      = 1'b0;
        last_sample = (rem_q == CW'(1));
        take        = (state_q == SCAN_RUN) && !stall;

        case (state_q)
            SCAN_IDLE: begin
                if (start_i) begin
                    accept = 1'b1;
                    if (count_i != '0) begin
                        state_d = SCAN_RUN;
                        query_d = base_i;
                        rem_d   = count_i;
                    end else begin
                        state_d = SCAN_DONE;
                    end
                end
            end
            SCAN_RUN: begin
                if (take) begin
                    query_d = query_q + QW'(1);
                    rem_d   = rem_q - CW'(1);
                    if (last_sample) begin
                        state_d = SCAN_FLUSH;
                    end
                end
            end
            SCAN_FLUSH: begin
                if (word_vld_o && word_rdy_i) begin
                    state_d = SCAN_DONE;
                end
            end
            SCAN_DONE: state_d = SCAN_IDLE;
            default:   state_d = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN_IDLE;
            query_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            query_q <= query_d;
            rem_q   <= rem_d;
        end
    end

    assign query_o     = query_q;
    assign query_vld_o = (state_q == SCAN_RUN);
    assign busy_o      = (state_q == SCAN_RUN) || (state_q == SCAN_FLUSH);
    assign done_o      = (state_q == SCAN_DONE);

    prm_scan_packer #(
        .WW (WW)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (accept),
        .sample_en_i (state_q == SCAN_RUN),
        .sample_i    (edge_mask_i),
        .last_i      (last_sample),
        .stall_o     (stall),
        .word_o      (word_o),
        .word_vld_o  (word_vld_o),
        .word_rdy_i  (word_rdy_i),
        .word_last_o (word_last_o)
    );

`ifdef PRM_SCAN_POPCNT_EN
    logic [CW-1:0] blk_q, blk_d;

    always_comb begin
        blk_d = blk_q;
        if (accept) begin
            blk_d = '0;
        end else if (take && edge_mask_i && (blk_q != '1)) begin
            blk_d = blk_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign blocked_cnt_o = blk_q;
`endif

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Self-checking bench for prm_edge_scan_ctrl: directed table, reset/popcount sequences
// and randomized commands checked against a bit-stream reference model.
`timescale 1ns/1ps
module tb_prm_edge_scan_ctrl;

    localparam int unsigned QW = 15;
    localparam int unsigned WW = 32;
    localparam int unsigned CW = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start_i = 1'b0;
    logic [QW-1:0] base_i  = '0;
    logic [CW-1:0] count_i = '0;
    logic          word_rdy_i = 1'b1;
    logic          busy_o, done_o, query_vld_o, edge_mask_i, word_vld_o, word_last_o;
    logic [QW-1:0] query_o;
    logic [WW-1:0] word_o;
`ifdef PRM_SCAN_POPCNT_EN
    logic [CW-1:0] blocked_cnt_o;
`endif

    bit mask_mem [32768];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Checker model: result is a pure function of the presented code.
    assign edge_mask_i = mask_mem[query_o];

    prm_edge_scan_ctrl #(
        .QW (QW),
        .WW (WW),
        .CW (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_i      (base_i),
        .count_i     (count_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .query_o     (query_o),
        .query_vld_o (query_vld_o),
        .edge_mask_i (edge_mask_i),
        .word_o      (word_o),
        .word_vld_o  (word_vld_o),
        .word_rdy_i  (word_rdy_i),
        .word_last_o (word_last_o)
`ifdef PRM_SCAN_POPCNT_EN
        ,
        .blocked_cnt_o (blocked_cnt_o)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // 0 all clear, 1 all blocked, 2 code bit0, 3 codes 5 and 40, otherwise random
    task automatic fill_mask(input int mode);
        for (int i = 0; i < 32768; i++) begin
            case (mode)
                0:       mask_mem[i] = 1'b0;
                1:       mask_mem[i] = 1'b1;
                2:       mask_mem[i] = i[0];
                3:       mask_mem[i] = (i == 5) || (i == 40);
                default: mask_mem[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 hold low stall_len cycles from first word
    task automatic run_cmd(input logic [QW-1:0] base, input int unsigned n,
                           input int rdy_mode, input int stall_len,
                           output int nw, output logic [WW-1:0] w_first,
                           output logic [WW-1:0] w_last, output int lat, output int stalls);
        logic [WW-1:0] exp_q[$];
        logic [WW-1:0] got_q[$];
        logic          gotl_q[$];
        logic [WW-1:0] acc;
        logic [WW-1:0] prev_word;
        logic [QW-1:0] qexp;
        int unsigned   j;
        int unsigned   exp_pop;
        int            hold_left;
        bit            prev_hold;
        bit            b;

        acc = '0;
        exp_pop = 0;
        for (int unsigned i = 0; i < n; i++) begin
            b = mask_mem[(32'(base) + i) % 32768];
            if (b) begin
                acc[i % WW] = 1'b1;
                exp_pop++;
            end
            if ((i % WW == WW - 1) || (i == n - 1)) begin
                exp_q.push_back(acc);
                acc = '0;
            end
        end

        nw = 0; w_first = '0; w_last = '0; lat = -1; stalls = 0;
        j = 0; hold_left = stall_len; prev_hold = 1'b0; prev_word = '0;

        @(negedge clk);
        base_i  = base;
        count_i = CW'(n);
        start_i = 1'b1;
        for (int cyc = 1; cyc <= 4 * int'(n) + 300; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            case (rdy_mode)
                0: word_rdy_i = 1'b1;
                1: word_rdy_i = 1'($urandom_range(0, 1));
                default: begin
                    if (word_vld_o && hold_left > 0) begin
                        word_rdy_i = 1'b0;
                        hold_left--;
                    end else begin
                        word_rdy_i = 1'b1;
                    end
                end
            endcase
            #1;
            if (cyc == 1) chk("busy_after_start", 64'(busy_o), 64'(n != 0));
            if (prev_hold) begin
                chk("hold_vld_stable", 64'(word_vld_o), 64'd1);
                chk("hold_word_stable", 64'(word_o), 64'(prev_word));
            end
            if (query_vld_o) begin
                qexp = QW'(32'(base) + j);
                chk("query_code", 64'(query_o), 64'(qexp));
                if (((j % WW == WW - 1) || (j == n - 1)) && word_vld_o && !word_rdy_i)
                    stalls++;
                else
                    j++;
            end
            if (word_vld_o && word_rdy_i) begin
                got_q.push_back(word_o);
                gotl_q.push_back(word_last_o);
                nw++;
            end
            prev_hold = word_vld_o && !word_rdy_i;
            prev_word = word_o;
            if (done_o) begin
                lat = cyc;
`ifdef PRM_SCAN_POPCNT_EN
                chk("popcount_at_done", 64'(blocked_cnt_o), 64'(exp_pop));
`endif
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 64'(done_o), 64'd1);

        chk("word_count", 64'(nw), 64'(exp_q.size()));
        for (int k = 0; k < nw && k < exp_q.size(); k++) begin
            chk("word_data", 64'(got_q[k]), 64'(exp_q[k]));
            chk("word_last", 64'(gotl_q[k]), 64'(k == exp_q.size() - 1));
        end
        if (nw > 0) begin
            w_first = got_q[0];
            w_last  = got_q[nw - 1];
        end
        @(negedge clk);
        #1;
        chk("done_single_pulse", 64'(done_o), 64'd0);
        chk("idle_not_busy", 64'(busy_o), 64'd0);
    endtask

    typedef struct {
        logic [QW-1:0] base;
        int unsigned   n;
        int            mask_mode;
        int            rdy_mode;
        int            stall_len;
        int            exp_nw;
        logic [WW-1:0] exp_first;
        logic [WW-1:0] exp_last;
        int            exp_lat;
        int            exp_stalls;
    } vec_t;

    vec_t tbl[7];

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_query"},     64'(query_o),     64'd0);
        chk({tag, "_query_vld"}, 64'(query_vld_o), 64'd0);
        chk({tag, "_busy"},      64'(busy_o),      64'd0);
        chk({tag, "_done"},      64'(done_o),      64'd0);
        chk({tag, "_word"},      64'(word_o),      64'd0);
        chk({tag, "_word_vld"},  64'(word_vld_o),  64'd0);
        chk({tag, "_word_last"}, 64'(word_last_o), 64'd0);
`ifdef PRM_SCAN_POPCNT_EN
        chk({tag, "_blocked"},   64'(blocked_cnt_o), 64'd0);
`endif
    endtask

    initial begin
        int nw, lat, st;
        logic [WW-1:0] wf, wl;

        tbl[0] = '{15'h0000, 32, 2, 0, 0,  1, 32'hAAAAAAAA, 32'hAAAAAAAA, 34, 0};
        tbl[1] = '{15'h7FF0, 40, 1, 0, 0,  2, 32'hFFFFFFFF, 32'h000000FF, 42, 0};
        tbl[2] = '{15'h0000, 64, 3, 2, 10, 2, 32'h00000020, 32'h00000100, 66, 0};
        tbl[3] = '{15'h0000, 64, 3, 2, 40, 2, 32'h00000020, 32'h00000100, 75, 9};
        tbl[4] = '{15'h0000, 0,  1, 0, 0,  0, 32'h0,        32'h0,        1,  0};
        tbl[5] = '{15'h1234, 1,  1, 0, 0,  1, 32'h00000001, 32'h00000001, 3,  0};
        tbl[6] = '{15'h0000, 33, 2, 0, 0,  2, 32'hAAAAAAAA, 32'h00000000, 35, 0};

        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            fill_mask(tbl[t].mask_mode);
            run_cmd(tbl[t].base, tbl[t].n, tbl[t].rdy_mode, tbl[t].stall_len, nw, wf, wl, lat, st);
            chk($sformatf("vec%0d_nwords", t), 64'(nw), 64'(tbl[t].exp_nw));
            chk($sformatf("vec%0d_done_lat", t), 64'(lat), 64'(tbl[t].exp_lat));
            chk($sformatf("vec%0d_stalls", t), 64'(st), 64'(tbl[t].exp_stalls));
            if (tbl[t].exp_nw > 0) begin
                chk($sformatf("vec%0d_first_word", t), 64'(wf), 64'(tbl[t].exp_first));
                chk($sformatf("vec%0d_last_word", t), 64'(wl), 64'(tbl[t].exp_last));
            end
        end

        // Reset in the middle of a command, after a word is already held.
        fill_mask(1);
        @(negedge clk);
        base_i = '0; count_i = CW'(64); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 80 && !(query_vld_o && query_o == 15'd40); c++) @(negedge clk);
        chk("midscan_reached", 64'(query_o), 64'd40);
        chk("midscan_word_held", 64'(word_o), 64'hFFFFFFFF);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_done_after_abort", 64'(done_o), 64'd0);
            chk("no_word_after_abort", 64'(word_vld_o), 64'd0);
        end
        run_cmd(15'h0100, 8, 0, 0, nw, wf, wl, lat, st);
        chk("post_reset_nwords", 64'(nw), 64'd1);
        chk("post_reset_word", 64'(wf), 64'h000000FF);
        chk("post_reset_lat", 64'(lat), 64'd10);

        // Start while busy must be ignored.
        fill_mask(1);
        @(negedge clk);
        base_i = 15'h0010; count_i = CW'(4); start_i = 1'b1;
        @(negedge clk);
        base_i = 15'h0500; count_i = CW'(9);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("busy_start_ignored", 64'(query_o), 64'h11);
        for (int c = 0; c < 20 && !done_o; c++) @(negedge clk);
        chk("busy_start_done", 64'(done_o), 64'd1);
        chk("busy_start_word", 64'(word_o), 64'hF);
        @(negedge clk);

`ifdef PRM_SCAN_POPCNT_EN
        fill_mask(0);
        mask_mem[16'h200] = 1'b1;
        mask_mem[16'h202] = 1'b1;
        mask_mem[16'h203] = 1'b1;
        run_cmd(15'h0200, 5, 0, 0, nw, wf, wl, lat, st);
        repeat (3) @(negedge clk);
        chk("popcount_stable", 64'(blocked_cnt_o), 64'd3);
        @(negedge clk);
        base_i = 15'h0000; count_i = CW'(3); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("popcount_cleared", 64'(blocked_cnt_o), 64'd0);
        for (int c = 0; c < 20 && !done_o; c++) @(negedge clk);
        @(negedge clk);
`endif

        for (int r = 0; r < 6; r++) begin
            fill_mask(4);
            run_cmd(QW'($urandom), $urandom_range(1, 100), 1, 0, nw, wf, wl, lat, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
